// File: rtl/input_conditioner_pkg.sv
// Shared defaults and helpers for the input conditioner (synchroniser + debounce + edge detect).
// Pure constants and functions; no timing or flow control involved.
package input_conditioner_pkg;

    localparam int CHANNELS_DEF = 8;
    localparam int STAGES_DEF   = 3;
    localparam int DEBOUNCE_DEF = 4;

    // Widest vector popcount accepts; callers zero-extend to this width.
    localparam int POP_MAX_W = 64;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int popcount(input logic [POP_MAX_W-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < POP_MAX_W; i++) begin
            if (v[i]) begin
                n++;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/sync_chain.sv
// WIDTH-bit, STAGES-deep synchroniser with per-bit reset value.
// Latency STAGES cycles; always shifts, no backpressure.
module sync_chain #(
    parameter int               WIDTH     = 1,
    parameter int               STAGES    = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [STAGES];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < STAGES; k++) begin
                stage[k] <= RESET_VAL;
            end
        end else begin
            stage[0] <= d;
            for (int k = 1; k < STAGES; k++) begin
                stage[k] <= stage[k-1];
            end
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/input_conditioner.sv
// Per-channel synchronise, debounce and edge-detect of raw board inputs, plus popcount of levels.
// Latency STAGES+DEBOUNCE cycles to y/rise/fall/count; en=0 freezes debounce state, no backpressure.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int                  CHANNELS  = CHANNELS_DEF,
    parameter int                  STAGES    = STAGES_DEF,
    parameter int                  DEBOUNCE  = DEBOUNCE_DEF,
    parameter logic [CHANNELS-1:0] RESET_VAL = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic [CHANNELS-1:0]           a,
    output logic [CHANNELS-1:0]           y,
    output logic [CHANNELS-1:0]           rise,
    output logic [CHANNELS-1:0]           fall,
    output logic [cnt_w(CHANNELS)-1:0]    count
);

    localparam int             CW        = cnt_w(CHANNELS);
    localparam int             DW        = cnt_w(DEBOUNCE);
    localparam logic [DW-1:0]  CNT_LAST  = DW'(DEBOUNCE - 1);
    localparam logic [CW-1:0]  COUNT_RST = CW'(popcount(POP_MAX_W'(RESET_VAL)));

    logic [CHANNELS-1:0] s;
    logic [CHANNELS-1:0] y_next;
    logic [DW-1:0]       cnt      [CHANNELS];
    logic [DW-1:0]       cnt_next [CHANNELS];

    sync_chain #(
        .WIDTH     (CHANNELS),
        .STAGES    (STAGES),
        .RESET_VAL (RESET_VAL)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (a),
        .q     (s)
    );

    // A disagreement must persist DEBOUNCE consecutive enabled cycles; any agreement restarts it.
    always_comb begin
        y_next = y;
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_next[i] = cnt[i];
            if (en) begin
                if (s[i] == y[i]) begin
                    cnt_next[i] = '0;
                end else if (cnt[i] == CNT_LAST) begin
                    y_next[i]   = s[i];
                    cnt_next[i] = '0;
                end else begin
                    cnt_next[i] = cnt[i] + DW'(1);
                end
            end
        end
    end

    // Edges and count derive from y_next so they line up with the cycle y changes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            y     <= RESET_VAL;
            rise  <= '0;
            fall  <= '0;
            count <= COUNT_RST;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            y     <= y_next;
            rise  <= y_next & ~y;
            fall  <= ~y_next & y;
            count <= CW'(popcount(POP_MAX_W'(y_next)));
            for (int i = 0; i < CHANNELS; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

endmodule
